el2_bp_ghr_unit: RTL and testbench
==================================

# el2_bp_ghr_unit

Parametrised global-history and branch-predictor index unit. It keeps a speculative and a retired global history register (GHR), computes a registered BHT index from the fetch PC folded with the speculative GHR, and checkpoints the GHR for every in-flight prediction so that a mispredict can restore history exactly. It sits between IFU fetch/predict and the EXU branch-resolve path. It supersedes the purely combinational PC/GHR hash helpers.

## Interface
- GHR_SIZE, 8: global history length in bits (≥2).
- IDX_W, 8: BHT index width.
- ADDR_LO, 4: lowest PC bit used by the address hash.
- FOLD2, 0: 1 = two-slice PC hash (slices 1 and 3); 0 = three-slice hash.
- CKPT_DEPTH, 4: checkpoint FIFO depth; must be a power of two, ≥2.
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  pipeline flush: restore the speculative GHR from the retired GHR and empty the FIFO.
- lookup_valid  in  1  index request.
- lookup_pc  in  31  PC[31:1]; must cover bit ADDR_LO+3*IDX_W-1.
- bht_index_valid  out  1  registered copy of lookup_valid.
- bht_index  out  IDX_W  registered index.
- pred_valid  in  1  a conditional branch was predicted.
- pred_taken  in  1  predicted direction.
- pred_ready  out  1  low when the FIFO is full.
- resolve_valid  in  1  oldest in-flight branch resolved.
- resolve_taken  in  1  actual direction.
- resolve_mispredict  in  1  the prediction was wrong.
- resolve_err  out  1  one-cycle pulse: resolve arrived while the FIFO was empty.
- ghr_spec  out  GHR_SIZE  speculative GHR.
- ghr_ret  out  GHR_SIZE  retired GHR.

## Operation
- **Address hash.**
  - Slice k (k = 0..2) is lookup_pc[ADDR_LO+k*IDX_W +: IDX_W].
  - H = s0^s1^s2, or s0^s2 when FOLD2=1.
- **GHR fold.** G = XOR of the GHR_SIZE bits split into IDX_W chunks from the LSB; the top chunk is zero-padded.
- **Index.** bht_index <= H ^ G, using ghr_spec as it was before any same-cycle update.
- **Accepted predict** (pred_valid & pred_ready):
  - Push the pre-update ghr_spec into the FIFO.
  - ghr_spec <= {ghr_spec[GHR_SIZE-2:0], pred_taken}.
- **Resolve** (resolve_valid, FIFO not empty):
  - Pop the oldest checkpoint C.
  - ghr_ret <= {ghr_ret[GHR_SIZE-2:0], resolve_taken}.
  - If mispredict: ghr_spec <= {C[GHR_SIZE-2:0], resolve_taken} and the FIFO empties, discarding all younger entries.
- **Resolve on empty FIFO:** no state change; resolve_err=1 for one cycle.
- **Priority within a cycle:** flush > mispredict-resolve > normal resolve + predict.
  - flush drops any same-cycle pred and resolve, including the ghr_ret update.
  - Mispredict drops a same-cycle pred.
  - Normal resolve + predict: pop and push in the same cycle, so the count is unchanged. This is allowed even when the FIFO is full, so pred_ready = !full | (resolve_valid & !resolve_mispredict).
- **Full FIFO:** pred_valid with pred_ready=0 is ignored; ghr_spec is unchanged.
- **Occupancy counter:** width $clog2(CKPT_DEPTH+1). Read and write pointers wrap modulo CKPT_DEPTH.

## Timing
- **Reset:** all GHRs, pointers and the count go to 0. bht_index_valid=0, bht_index=0, resolve_err=0. pred_ready=1.
- **Lookup latency:** 1 cycle.
- **GHR and pred_ready latency:** ghr_spec and ghr_ret are registered and change the cycle after the event. pred_ready is combinational from the count and the resolve inputs.
- **Reset asserted mid-operation:** all state clears immediately (asynchronously). Normal operation resumes the first clock after deassertion.
- **Flush:** the cycle after flush, ghr_spec equals ghr_ret and the count is 0.

## Structure
- Package el2_bp_pkg:
  - function bp_fold(ghr): the GHR fold.
  - function bp_addr_hash(pc, fold2): the address hash.
  - typedef ghr_t.
- Sub-module el2_bp_ckpt_fifo:
  - Parameters: width, depth.
  - Ports: push/pop/clear, full/empty, head data.
  - It must support push and pop in the same cycle when full.

## Test plan
- **Reset, then FOLD2=0, IDX_W=8, ADDR_LO=4.** lookup_pc[27:4]=0x123456 with GHR=0. Next cycle: bht_index=0x12^0x34^0x56=0x70, valid=1.
- **Predicts then mispredict.** Predict T,N,T from GHR=0 → ghr_spec=0x05, count 3. Resolve the first branch as mispredict with taken=0 → ghr_spec=0x00, count 0, ghr_ret=0x00.
- **Full FIFO.** Four predicts (taken) fill it → pred_ready=0. A fifth predict is ignored (ghr_spec stays 0x0F). A fifth predict together with a normal resolve is accepted → ghr_spec=0x1F, count 4.
- **Flush priority.** flush with pred_valid and resolve_valid in the same cycle → ghr_spec=ghr_ret (retired unchanged), count 0.
- **Resolve on empty.** resolve_valid with an empty FIFO → resolve_err pulses one cycle; both GHRs unchanged.
- **GHR wider than index.** GHR_SIZE=12, IDX_W=8, GHR=0xABC, PC hash 0 → bht_index=0xBC^0x0A=0xB6.

Source files
------------

// File: rtl/el2_bp_pkg.sv
// Shared types and hash helpers for the branch-predictor global-history unit.
package el2_bp_pkg;

  // Container width for history and hash arithmetic; GHR_SIZE and IDX_W must not exceed it.
  localparam int BP_MAX_W = 64;

  typedef logic [BP_MAX_W-1:0] ghr_t;

  // Low-order mask of idx_w ones.
  function automatic ghr_t bp_mask(input int idx_w);
    return (ghr_t'(1'b1) << idx_w) - ghr_t'(1'b1);
  endfunction

  // XOR-fold a zero-extended history into idx_w-bit chunks starting at the LSB.
  // Bits above the real history length are zero, which pads the top chunk.
  function automatic ghr_t bp_fold(input ghr_t ghr, input int idx_w);
    ghr_t res;
    ghr_t mask;
    res  = {BP_MAX_W{1'b0}};
    mask = bp_mask(idx_w);
    for (int c = 0; c < BP_MAX_W; c++) begin
      if (c * idx_w < BP_MAX_W) begin
        res = res ^ ((ghr >> (c * idx_w)) & mask);
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // XOR of the idx_w-bit PC slices starting at addr_lo; fold2 skips the middle slice.
  function automatic ghr_t bp_addr_hash(input ghr_t pc, input logic fold2,
                                        input int addr_lo, input int idx_w);
    ghr_t mask;
    ghr_t s0;
    ghr_t s1;
    ghr_t s2;
    ghr_t res;
    mask = bp_mask(idx_w);
    s0   = (pc >> addr_lo) & mask;
    s1   = (pc >> (addr_lo + idx_w)) & mask;
    s2   = (pc >> (addr_lo + 2 * idx_w)) & mask;
    if (fold2) begin
      res = s0 ^ s2;
    end else begin
      res = s0 ^ s1 ^ s2;
    end
    return res;
  endfunction

endpackage

// File: rtl/el2_bp_ckpt_fifo.sv
// Checkpoint FIFO holding the speculative GHR for each in-flight prediction.
// Push and pop may coincide even when full; clear empties it and wins over both.
module el2_bp_ckpt_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == {CNT_W{1'b0}});
  assign head      = mem_r[rd_ptr_r];
  assign do_pop_s  = pop & ~empty;
  assign do_push_s = push & (~full | do_pop_s);

  // Checkpoint storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push_s & ~clear) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; count tracks occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else if (clear) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/el2_bp_ghr_unit.sv
// Global-history unit: speculative/retired GHRs, registered BHT index,
// and per-prediction GHR checkpoints for exact history repair on mispredict.
module el2_bp_ghr_unit
  import el2_bp_pkg::*;
#(
  parameter int GHR_SIZE   = 8,
  parameter int IDX_W      = 8,
  parameter int ADDR_LO    = 4,
  parameter int FOLD2      = 0,
  parameter int CKPT_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                lookup_valid,
  input  logic [30:0]         lookup_pc,
  output logic                bht_index_valid,
  output logic [IDX_W-1:0]    bht_index,
  input  logic                pred_valid,
  input  logic                pred_taken,
  output logic                pred_ready,
  input  logic                resolve_valid,
  input  logic                resolve_taken,
  input  logic                resolve_mispredict,
  output logic                resolve_err,
  output logic [GHR_SIZE-1:0] ghr_spec,
  output logic [GHR_SIZE-1:0] ghr_ret
);

  logic [GHR_SIZE-1:0] ghr_spec_r;
  logic [GHR_SIZE-1:0] ghr_ret_r;
  logic [GHR_SIZE-1:0] ghr_spec_nxt_s;
  logic [GHR_SIZE-1:0] ckpt_head_s;
  logic [IDX_W-1:0]    bht_index_r;
  logic [IDX_W-1:0]    index_nxt_s;
  logic                bht_index_valid_r;
  logic                resolve_err_r;
  logic                fifo_full_s;
  logic                fifo_empty_s;
  logic                resolve_ok_s;
  logic                mispred_s;
  logic                push_s;
  logic                clear_s;
  ghr_t                hash_s;
  ghr_t                fold_s;

  // A full FIFO can still take a predict when a normal resolve frees a slot the same cycle.
  assign pred_ready   = ~fifo_full_s | (resolve_valid & ~resolve_mispredict);
  assign resolve_ok_s = resolve_valid & ~fifo_empty_s & ~flush;
  assign mispred_s    = resolve_ok_s & resolve_mispredict;
  assign push_s       = pred_valid & pred_ready & ~flush & ~mispred_s;
  assign clear_s      = flush | mispred_s;

  // Index hash uses the speculative GHR before any same-cycle update.
  always_comb begin
    hash_s      = bp_addr_hash(ghr_t'(lookup_pc), (FOLD2 != 0), ADDR_LO, IDX_W);
    fold_s      = bp_fold(ghr_t'(ghr_spec_r), IDX_W);
    index_nxt_s = hash_s[IDX_W-1:0] ^ fold_s[IDX_W-1:0];
  end

  // Speculative GHR next state: flush > mispredict repair > accepted predict.
  always_comb begin
    if (flush) begin
      ghr_spec_nxt_s = ghr_ret_r;
    end else if (mispred_s) begin
      ghr_spec_nxt_s = {ckpt_head_s[GHR_SIZE-2:0], resolve_taken};
    end else if (push_s) begin
      ghr_spec_nxt_s = {ghr_spec_r[GHR_SIZE-2:0], pred_taken};
    end else begin
      ghr_spec_nxt_s = ghr_spec_r;
    end
  end

  // History registers, registered index and the empty-resolve error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr_spec_r        <= {GHR_SIZE{1'b0}};
      ghr_ret_r         <= {GHR_SIZE{1'b0}};
      bht_index_r       <= {IDX_W{1'b0}};
      bht_index_valid_r <= 1'b0;
      resolve_err_r     <= 1'b0;
    end else begin
      ghr_spec_r        <= ghr_spec_nxt_s;
      ghr_ret_r         <= resolve_ok_s ? {ghr_ret_r[GHR_SIZE-2:0], resolve_taken} : ghr_ret_r;
      bht_index_r       <= lookup_valid ? index_nxt_s : bht_index_r;
      bht_index_valid_r <= lookup_valid;
      resolve_err_r     <= resolve_valid & fifo_empty_s & ~flush;
    end
  end

  el2_bp_ckpt_fifo #(
    .WIDTH (GHR_SIZE),
    .DEPTH (CKPT_DEPTH)
  ) u_ckpt (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (resolve_ok_s),
    .clear (clear_s),
    .din   (ghr_spec_r),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .head  (ckpt_head_s)
  );

  assign ghr_spec        = ghr_spec_r;
  assign ghr_ret         = ghr_ret_r;
  assign bht_index       = bht_index_r;
  assign bht_index_valid = bht_index_valid_r;
  assign resolve_err     = resolve_err_r;

endmodule

// File: tb/tb_el2_bp_ghr_unit.sv
// Directed bench for el2_bp_ghr_unit: a default 8-bit instance driven from a
// vector table, plus a 12-bit/FOLD2 instance and an async-reset sequence.
module tb_el2_bp_ghr_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: GHR_SIZE=8, IDX_W=8, ADDR_LO=4, FOLD2=0, depth 4
  logic        a_flush, a_lv, a_pv, a_pt, a_rv, a_rt, a_rm;
  logic [30:0] a_pc;
  logic        a_iv, a_ready, a_err;
  logic [7:0]  a_idx, a_spec, a_ret;

  // Instance B: GHR_SIZE=12, IDX_W=8, ADDR_LO=4, FOLD2=1, depth 16
  logic        b_flush, b_lv, b_pv, b_pt, b_rv, b_rt, b_rm;
  logic [30:0] b_pc;
  logic        b_iv, b_ready, b_err;
  logic [7:0]  b_idx;
  logic [11:0] b_spec, b_ret;

  el2_bp_ghr_unit #(.GHR_SIZE(8), .IDX_W(8), .ADDR_LO(4), .FOLD2(0), .CKPT_DEPTH(4)) dut_a (
    .clk(clk), .rst(rst), .flush(a_flush), .lookup_valid(a_lv), .lookup_pc(a_pc),
    .bht_index_valid(a_iv), .bht_index(a_idx), .pred_valid(a_pv), .pred_taken(a_pt),
    .pred_ready(a_ready), .resolve_valid(a_rv), .resolve_taken(a_rt),
    .resolve_mispredict(a_rm), .resolve_err(a_err), .ghr_spec(a_spec), .ghr_ret(a_ret)
  );

  el2_bp_ghr_unit #(.GHR_SIZE(12), .IDX_W(8), .ADDR_LO(4), .FOLD2(1), .CKPT_DEPTH(16)) dut_b (
    .clk(clk), .rst(rst), .flush(b_flush), .lookup_valid(b_lv), .lookup_pc(b_pc),
    .bht_index_valid(b_iv), .bht_index(b_idx), .pred_valid(b_pv), .pred_taken(b_pt),
    .pred_ready(b_ready), .resolve_valid(b_rv), .resolve_taken(b_rt),
    .resolve_mispredict(b_rm), .resolve_err(b_err), .ghr_spec(b_spec), .ghr_ret(b_ret)
  );

  typedef struct {
    logic       lv;
    logic [30:0] pc;
    logic       pv, pt, rv, rt, rm, fl;
    logic       e_ready;
    logic [7:0] e_spec, e_ret;
    logic       e_iv;
    logic [7:0] e_idx;
    logic       e_err;
  } vec_t;

  localparam int NV = 26;
  localparam logic [30:0] PC_A = 31'h1234560;
  vec_t vecs [NV];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic row(input int i, input logic lv, input logic [30:0] pc,
                     input logic pv, input logic pt, input logic rv, input logic rt,
                     input logic rm, input logic fl, input logic e_ready,
                     input logic [7:0] e_spec, input logic [7:0] e_ret,
                     input logic e_iv, input logic [7:0] e_idx, input logic e_err);
    vecs[i] = '{lv, pc, pv, pt, rv, rt, rm, fl, e_ready, e_spec, e_ret, e_iv, e_idx, e_err};
  endtask

  task automatic idle_a();
    a_flush = 1'b0; a_lv = 1'b0; a_pc = 31'h0; a_pv = 1'b0; a_pt = 1'b0;
    a_rv = 1'b0; a_rt = 1'b0; a_rm = 1'b0;
  endtask

  task automatic idle_b();
    b_flush = 1'b0; b_lv = 1'b0; b_pc = 31'h0; b_pv = 1'b0; b_pt = 1'b0;
    b_rv = 1'b0; b_rt = 1'b0; b_rm = 1'b0;
  endtask

  logic [11:0] pattern;

  initial begin
    //      i  lv   pc    pv pt rv rt rm fl  rdy  spec   ret    iv  idx    err
    row( 0, 1, PC_A, 0, 0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 1, 8'h70, 0); // hash 12^34^56
    row( 1, 0, 31'h0, 1, 1, 0, 0, 0, 0, 1, 8'h01, 8'h00, 0, 8'h70, 0); // predict T
    row( 2, 0, 31'h0, 1, 0, 0, 0, 0, 0, 1, 8'h02, 8'h00, 0, 8'h70, 0); // predict N
    row( 3, 0, 31'h0, 1, 1, 0, 0, 0, 0, 1, 8'h05, 8'h00, 0, 8'h70, 0); // predict T
    row( 4, 1, 31'h0, 0, 0, 0, 0, 0, 0, 1, 8'h05, 8'h00, 1, 8'h05, 0); // fold of GHR only
    row( 5, 0, 31'h0, 0, 0, 1, 0, 1, 0, 1, 8'h00, 8'h00, 0, 8'h05, 0); // mispredict oldest
    row( 6, 0, 31'h0, 0, 0, 1, 1, 0, 0, 1, 8'h00, 8'h00, 0, 8'h05, 1); // resolve on empty
    row( 7, 0, 31'h0, 0, 0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 0, 8'h05, 0); // err is a pulse
    row( 8, 0, 31'h0, 1, 1, 0, 0, 0, 0, 1, 8'h01, 8'h00, 0, 8'h05, 0);
    row( 9, 0, 31'h0, 1, 1, 0, 0, 0, 0, 1, 8'h03, 8'h00, 0, 8'h05, 0);
    row(10, 0, 31'h0, 1, 1, 0, 0, 0, 0, 1, 8'h07, 8'h00, 0, 8'h05, 0);
    row(11, 0, 31'h0, 1, 1, 0, 0, 0, 0, 1, 8'h0F, 8'h00, 0, 8'h05, 0); // now full
    row(12, 0, 31'h0, 1, 1, 0, 0, 0, 0, 0, 8'h0F, 8'h00, 0, 8'h05, 0); // ignored when full
    row(13, 0, 31'h0, 1, 1, 1, 1, 0, 0, 1, 8'h1F, 8'h01, 0, 8'h05, 0); // push+pop while full
    row(14, 0, 31'h0, 1, 1, 0, 0, 0, 0, 0, 8'h1F, 8'h01, 0, 8'h05, 0); // still full
    row(15, 0, 31'h0, 1, 1, 1, 1, 0, 1, 1, 8'h01, 8'h01, 0, 8'h05, 0); // flush wins
    row(16, 0, 31'h0, 0, 0, 1, 1, 0, 0, 1, 8'h01, 8'h01, 0, 8'h05, 1); // FIFO empty after flush
    row(17, 1, 31'h0, 1, 1, 0, 0, 0, 0, 1, 8'h03, 8'h01, 1, 8'h01, 0); // index uses pre-update GHR
    row(18, 0, 31'h0, 1, 0, 1, 1, 1, 0, 1, 8'h03, 8'h03, 0, 8'h01, 0); // mispredict drops pred
    row(19, 0, 31'h0, 0, 0, 0, 0, 0, 0, 1, 8'h03, 8'h03, 0, 8'h01, 0);
    row(20, 0, 31'h0, 1, 1, 0, 0, 0, 0, 1, 8'h07, 8'h03, 0, 8'h01, 0);
    row(21, 0, 31'h0, 1, 1, 0, 0, 0, 0, 1, 8'h0F, 8'h03, 0, 8'h01, 0);
    row(22, 0, 31'h0, 1, 1, 0, 0, 0, 0, 1, 8'h1F, 8'h03, 0, 8'h01, 0);
    row(23, 0, 31'h0, 0, 0, 1, 1, 0, 0, 1, 8'h1F, 8'h07, 0, 8'h01, 0); // pops ckpt 03
    row(24, 0, 31'h0, 0, 0, 1, 0, 1, 0, 1, 8'h0E, 8'h0E, 0, 8'h01, 0); // repairs from ckpt 07
    row(25, 1, PC_A, 0, 0, 0, 0, 0, 0, 1, 8'h0E, 8'h0E, 1, 8'h7E, 0); // 70 ^ fold(0E)

    idle_a();
    idle_b();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset a_spec",  32'(a_spec),  32'h0);
    chk("reset a_ret",   32'(a_ret),   32'h0);
    chk("reset a_iv",    32'(a_iv),    32'h0);
    chk("reset a_idx",   32'(a_idx),   32'h0);
    chk("reset a_err",   32'(a_err),   32'h0);
    chk("reset a_ready", 32'(a_ready), 32'h1);
    chk("reset b_spec",  32'(b_spec),  32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      a_lv = vecs[i].lv; a_pc = vecs[i].pc; a_pv = vecs[i].pv; a_pt = vecs[i].pt;
      a_rv = vecs[i].rv; a_rt = vecs[i].rt; a_rm = vecs[i].rm; a_flush = vecs[i].fl;
      #1;
      chk($sformatf("row%0d ready", i), 32'(a_ready), 32'(vecs[i].e_ready));
      @(posedge clk);
      #1;
      chk($sformatf("row%0d spec", i), 32'(a_spec), 32'(vecs[i].e_spec));
      chk($sformatf("row%0d ret", i),  32'(a_ret),  32'(vecs[i].e_ret));
      chk($sformatf("row%0d iv", i),   32'(a_iv),   32'(vecs[i].e_iv));
      chk($sformatf("row%0d idx", i),  32'(a_idx),  32'(vecs[i].e_idx));
      chk($sformatf("row%0d err", i),  32'(a_err),  32'(vecs[i].e_err));
    end
    @(negedge clk);
    idle_a();

    // Instance B: build GHR=0xABC by predicting its bits MSB first.
    pattern = 12'hABC;
    for (int k = 11; k >= 0; k--) begin
      @(negedge clk);
      b_pv = 1'b1;
      b_pt = pattern[k];
      #1;
      chk($sformatf("b ready bit%0d", k), 32'(b_ready), 32'h1);
    end
    @(negedge clk);
    idle_b();
    chk("b spec ABC", 32'(b_spec), 32'hABC);
    chk("b ret idle", 32'(b_ret),  32'h0);
    b_lv = 1'b1;
    b_pc = 31'h0;
    @(posedge clk);
    #1;
    chk("b idx pc0",  32'(b_idx), 32'hB6);
    chk("b iv pc0",   32'(b_iv),  32'h1);
    @(negedge clk);
    b_pc = PC_A;
    @(posedge clk);
    #1;
    chk("b idx fold2", 32'(b_idx), 32'hF2);
    @(negedge clk);
    idle_b();

    // Asynchronous reset in the middle of a cycle, with no clock edge in between.
    a_pv = 1'b1;
    a_pt = 1'b1;
    @(posedge clk);
    #1;
    chk("pre-reset a_spec", 32'(a_spec), 32'h1D);
    #2;
    rst = 1'b1;
    #1;
    chk("async a_spec", 32'(a_spec), 32'h0);
    chk("async a_ret",  32'(a_ret),  32'h0);
    chk("async a_idx",  32'(a_idx),  32'h0);
    chk("async b_spec", 32'(b_spec), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("resume a_spec", 32'(a_spec), 32'h01);
    @(negedge clk);
    idle_a();
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
